mem_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single memory port between instruction fetch (master 0, read-only) and load/store (master 1, read/write).
- Handshake is strobe/acknowledge on every side: master holds stb until ack; slave asserts ack with valid read data.
- Round-robin on contention, one transaction in flight.
- Sits between the core's fetch/LSU and the memory model.

---
 rtl/mem_bus_arbiter_pkg.sv | 9 +
 rtl/mem_bus_arbiter_arb_rr2.sv | 12 +
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_e;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 16;
endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// Two-way round-robin picker: a tie goes to the master that did not win last.
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       any
);
  assign any = |req;
  assign gnt = (&req) ? ~last_gnt : (req[1] ? GNT_DATA : GNT_FETCH);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch (m0, read-only) and load/store (m1).
// Define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES without slave ack.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_stb,
  input  logic [ADDR_W-1:0]   m0_addr,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_data,
  output logic                m0_err,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_sel,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_sel,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                o_gnt
);
  arb_state_e state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d;
  logic pick_gnt, pick_any;
  logic busy, cur_stb, live, sel_m0, sel_m1, to_fire;

  arb_rr2 u_rr (
    .req      ({m1_stb, m0_stb}),
    .last_gnt (last_q),
    .gnt      (pick_gnt),
    .any      (pick_any)
  );

  assign busy    = (state_q == ARB_BUSY);
  assign cur_stb = (gnt_q == GNT_DATA) ? m1_stb : m0_stb;
  // live gates every output, so reset and an abandoned request both silence the bus
  assign live    = busy & cur_stb & ~rst;
  assign sel_m0  = live & (gnt_q == GNT_FETCH);
  assign sel_m1  = live & (gnt_q == GNT_DATA);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || !busy) cnt_q <= '0;
    else if (!s_ack)  cnt_q <= cnt_q + CNT_W'(1);
  end

  // an ack in the expiry cycle takes priority over the abort
  assign to_fire = live & ~s_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_fire = 1'b0;
`endif

  assign s_stb    = live & ~to_fire;
  assign s_we     = sel_m1 & m1_we;
  assign s_addr   = sel_m1 ? m1_addr : (sel_m0 ? m0_addr : '0);
  assign s_wdata  = sel_m1 ? m1_wdata : '0;
  assign s_sel    = sel_m1 ? m1_sel : (sel_m0 ? '1 : '0);
  assign m0_ack   = sel_m0 & s_ack;
  assign m1_ack   = sel_m1 & s_ack;
  assign m0_data  = sel_m0 ? s_rdata : '0;
  assign m1_rdata = sel_m1 ? s_rdata : '0;
  assign m0_err   = sel_m0 & to_fire;
  assign m1_err   = sel_m1 & to_fire;
  assign o_gnt    = gnt_q & ~rst;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          gnt_d   = pick_gnt;
        end
      end
      ARB_BUSY: begin
        // a dropped strobe abandons the transfer without moving the round-robin pointer
        if (!cur_stb) begin
          state_d = ARB_IDLE;
        end else if (s_ack || to_fire) begin
          state_d = ARB_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_FETCH;
      last_q  <= GNT_DATA;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scenario bench for mem_bus_arbiter; expected acks are queued when requests are issued.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_data;
  logic        m1_stb, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_sel;
  logic        s_stb, s_we, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        o_gnt;
  logic        mem_rdy;
  logic [31:0] mem_data;

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory model: acks whenever ready, even in IDLE, which the arbiter must ignore
  assign s_ack   = mem_rdy;
  assign s_rdata = mem_data;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_data(m0_data), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel),
    .s_ack(s_ack), .s_rdata(s_rdata), .o_gnt(o_gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_stb = 0; m0_addr = 0; m1_stb = 0; m1_we = 0; m1_addr = 0;
    m1_wdata = 0; m1_sel = 0; mem_rdy = 1'b1; mem_data = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin m0_stb = 1'b1; m1_stb = 1'b1; end
      mid();
      checks++;
      if ({s_stb, s_we, s_addr, s_wdata, s_sel, m0_ack, m0_data, m0_err, m1_ack, m1_rdata, m1_err, o_gnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: s_stb=%b s_addr=%h m0_ack=%b m1_ack=%b o_gnt=%b want all 0",
                 i, s_stb, s_addr, m0_ack, m1_ack, o_gnt);
      end
    end
    tick();
    rst = 1'b0; m0_stb = 0; m1_stb = 0;
    mid();
    checks++;
    if ({s_stb, m0_ack, m1_ack, m0_data, m1_rdata, o_gnt} !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: s_stb=%b m0_ack=%b m1_ack=%b o_gnt=%b want 0", s_stb, m0_ack, m1_ack, o_gnt);
    end
  endtask

  task automatic test_fetch();
    exp_t e;
    tick();
    m0_stb = 1'b1; m0_addr = 32'h0000_0004; mem_data = 32'h0041_0113; mem_rdy = 1'b1;
    sb.push_back('{owner: 1'b0, data: 32'h0041_0113});
    mid();
    checks++;
    if (s_stb !== 1'b0) begin errors++; $display("FAIL fetch_no_comb_stb: s_stb=%b want 0", s_stb); end
    tick(); mid();
    checks++;
    if (s_stb !== 1'b1 || s_addr !== 32'h4 || s_we !== 1'b0 || s_sel !== 4'hf) begin
      errors++;
      $display("FAIL fetch_bus: stb=%b addr=%h we=%b sel=%h want 1 00000004 0 f", s_stb, s_addr, s_we, s_sel);
    end
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_ack: m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
    end
    if (sb.size() == 0) begin errors++; $display("FAIL fetch_sb: queue empty"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (m0_data !== e.data) begin errors++; $display("FAIL fetch_data: got %h want %h", m0_data, e.data); end
    end
    tick();
    m0_stb = 1'b0;
    mid();
    checks++;
    if (s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_idle_gap: s_stb=%b m0_ack=%b m1_ack=%b want 0", s_stb, m0_ack, m1_ack);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    logic exp_owner, got_ack, oth_ack;
    logic [31:0] got_data;
    tick();
    rst = 1'b1; m0_stb = 1'b1; m0_addr = 32'h20; m1_stb = 1'b1; m1_we = 1'b0;
    m1_addr = 32'h40; m1_sel = 4'hf; mem_rdy = 1'b1;
    for (int j = 0; j < 4; j++) sb.push_back('{owner: j[0], data: 32'h5A5A_0000 + 32'(2 * j + 1)});
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      mem_data = 32'h5A5A_0000 + 32'(k);
      mid();
      checks++;
      if (k % 2 == 0) begin
        if (s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
          errors++; $display("FAIL contention_gap cyc%0d: s_stb=%b m0_ack=%b m1_ack=%b want 0", k, s_stb, m0_ack, m1_ack);
        end
      end else begin
        exp_owner = ((k - 1) / 2) % 2 == 1;
        if (o_gnt !== exp_owner || s_stb !== 1'b1) begin
          errors++; $display("FAIL contention_gnt cyc%0d: o_gnt=%b s_stb=%b want %b 1", k, o_gnt, s_stb, exp_owner);
        end
        if (sb.size() == 0) begin errors++; $display("FAIL contention_sb cyc%0d: queue empty", k); end
        else begin
          e = sb.pop_front();
          got_ack  = e.owner ? m1_ack : m0_ack;
          oth_ack  = e.owner ? m0_ack : m1_ack;
          got_data = e.owner ? m1_rdata : m0_data;
          checks++;
          if (got_ack !== 1'b1 || oth_ack !== 1'b0 || got_data !== e.data) begin
            errors++;
            $display("FAIL contention_ack cyc%0d: owner%0d ack=%b other=%b data=%h want 1 0 %h",
                     k, e.owner, got_ack, oth_ack, got_data, e.data);
          end
        end
      end
    end
    tick();
    m0_stb = 1'b0; m1_stb = 1'b0;
  endtask

  task automatic test_store();
    exp_t e;
    tick();
    m1_stb = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hDEAD_BEEF; m1_sel = 4'b0011;
    mem_data = 32'hCAFE_F00D; mem_rdy = 1'b1;
    sb.push_back('{owner: 1'b1, data: 32'hCAFE_F00D});
    mid();
    checks++;
    if (s_stb !== 1'b0) begin errors++; $display("FAIL store_no_comb_stb: s_stb=%b want 0", s_stb); end
    tick(); mid();
    checks++;
    if ({s_stb, s_we, s_addr, s_wdata, s_sel} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++;
      $display("FAIL store_bus: stb=%b we=%b addr=%h wdata=%h sel=%b want 1 1 00000100 deadbeef 0011",
               s_stb, s_we, s_addr, s_wdata, s_sel);
    end
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || o_gnt !== 1'b1) begin
      errors++; $display("FAIL store_ack: m1_ack=%b m0_ack=%b o_gnt=%b want 1 0 1", m1_ack, m0_ack, o_gnt);
    end
    if (sb.size() == 0) begin errors++; $display("FAIL store_sb: queue empty"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (m1_rdata !== e.data) begin errors++; $display("FAIL store_rdata: got %h want %h", m1_rdata, e.data); end
    end
    tick();
    m1_stb = 1'b0; m1_we = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    tick();
    m1_stb = 1'b1; m1_addr = 32'h200; mem_rdy = 1'b0;
    tick(); tick(); mid();
    checks++;
    if (s_stb !== 1'b1 || m1_ack !== 1'b0 || o_gnt !== 1'b1) begin
      errors++; $display("FAIL abort_stall: s_stb=%b m1_ack=%b o_gnt=%b want 1 0 1", s_stb, m1_ack, o_gnt);
    end
    tick();
    m1_stb = 1'b0;
    mid();
    checks++;
    if (s_stb !== 1'b0 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL abort_drop: s_stb=%b m1_ack=%b want 0 0", s_stb, m1_ack);
    end
    tick();
    m0_stb = 1'b1; m0_addr = 32'h8; mem_rdy = 1'b1; mem_data = 32'h0000_0033;
    sb.push_back('{owner: 1'b0, data: 32'h0000_0033});
    mid();
    checks++;
    if (s_stb !== 1'b0) begin errors++; $display("FAIL abort_idle: s_stb=%b want 0", s_stb); end
    tick(); mid();
    checks++;
    if (s_stb !== 1'b1 || o_gnt !== 1'b0 || m0_ack !== 1'b1 || s_addr !== 32'h8) begin
      errors++; $display("FAIL abort_regrant: s_stb=%b o_gnt=%b m0_ack=%b addr=%h want 1 0 1 00000008",
                         s_stb, o_gnt, m0_ack, s_addr);
    end
    if (sb.size() == 0) begin errors++; $display("FAIL abort_sb: queue empty"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (m0_data !== e.data) begin errors++; $display("FAIL abort_data: got %h want %h", m0_data, e.data); end
    end
    tick();
    m0_stb = 1'b0;
  endtask

  task automatic test_reset_busy();
    exp_t e;
    tick();
    m1_stb = 1'b1; m1_addr = 32'h300; mem_rdy = 1'b0;
    tick(); tick(); mid();
    checks++;
    if (s_stb !== 1'b1) begin errors++; $display("FAIL rstbusy_stall: s_stb=%b want 1", s_stb); end
    tick();
    rst = 1'b1; mem_rdy = 1'b1; mem_data = 32'h7777_0001;
    mid();
    checks++;
    if ({s_stb, s_we, s_addr, s_wdata, s_sel, m0_ack, m0_data, m0_err, m1_ack, m1_rdata, m1_err, o_gnt} !== '0) begin
      errors++; $display("FAIL rstbusy_outputs: s_stb=%b m1_ack=%b m1_rdata=%h o_gnt=%b want 0",
                         s_stb, m1_ack, m1_rdata, o_gnt);
    end
    tick();
    rst = 1'b0; mem_data = 32'h7777_0002;
    sb.push_back('{owner: 1'b1, data: 32'h7777_0002});
    mid();
    checks++;
    if (s_stb !== 1'b0 || m1_ack !== 1'b0 || o_gnt !== 1'b0) begin
      errors++; $display("FAIL rstbusy_idle: s_stb=%b m1_ack=%b o_gnt=%b want 0 0 0", s_stb, m1_ack, o_gnt);
    end
    tick(); mid();
    if (sb.size() == 0) begin errors++; $display("FAIL rstbusy_sb: queue empty"); end
    else begin
      e = sb.pop_front();
      checks++;
      if (m1_ack !== 1'b1 || m1_rdata !== e.data) begin
        errors++; $display("FAIL rstbusy_regrant: m1_ack=%b rdata=%h want 1 %h", m1_ack, m1_rdata, e.data);
      end
    end
    tick();
    m1_stb = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    m0_stb = 1'b1; m0_addr = 32'h40; mem_rdy = 1'b0;
`ifdef ARB_TIMEOUT_EN
    begin
      int err_at = -1;
      int err_cnt = 0;
      logic stb_after = 1'bx;
      for (int k = 1; k <= 30; k++) begin
        tick(); mid();
        if (k == err_at + 1 && err_at > 0) stb_after = s_stb;
        if (m0_err === 1'b1) begin
          err_cnt++;
          if (err_at < 0) err_at = k;
          checks++;
          if (s_stb !== 1'b0 || m0_ack !== 1'b0 || m1_err !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_bus: s_stb=%b m0_ack=%b m1_err=%b want 0 0 0", s_stb, m0_ack, m1_err);
          end
        end
      end
      checks++;
      if (err_cnt != 1 || err_at != 16) begin
        errors++; $display("FAIL timeout_when: err pulses=%0d at busy cycle %0d want 1 at 16", err_cnt, err_at);
      end
      checks++;
      if (stb_after !== 1'b0) begin errors++; $display("FAIL timeout_idle: s_stb=%b after err want 0", stb_after); end
    end
`else
    begin
      int bad = 0;
      for (int k = 1; k <= 100; k++) begin
        tick(); mid();
        if (s_stb !== 1'b1 || m0_err !== 1'b0 || m1_err !== 1'b0 || m0_ack !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL no_timeout_wait: %0d bad cycles want 0", bad); end
    end
`endif
    tick();
    m0_stb = 1'b0;
    mid();
    checks++;
    if (s_stb !== 1'b0 || m0_err !== 1'b0) begin
      errors++; $display("FAIL timeout_release: s_stb=%b m0_err=%b want 0 0", s_stb, m0_err);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_abort();
    test_reset_busy();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
